// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch, data memory) in front of one
// single-port RAM. Round-robin on ties, registered RAM command, bounded
// wait for ram_ready with an error flag on timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        err,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        stall_if,
  output logic        stall_dm
);

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM} state_e;

  // The counter is cleared on entry and compared before incrementing, so
  // matching TIMEOUT_CYC-1 at an edge means this is the TIMEOUT_CYC-th
  // BUSY cycle without ready.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        last_dm_q, last_dm_d;   // 1: DM held the last grant
  logic [7:0]  cnt_q, cnt_d;
  logic        ce_q, ce_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, err_q, err_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        grant_dm, done, busy_dm;

  // Next-state and datapath: grant in IDLE, wait in BUSY, one-cycle ack in RESP.
  always_comb begin
    state_d    = state_q;
    last_dm_d  = last_dm_q;
    cnt_d      = cnt_q;
    ce_d       = ce_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = dm_req & (~if_req | ~last_dm_q);
    busy_dm    = (state_q == BUSY_DM);
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          cnt_d     = '0;
          ce_d      = 1'b1;
          last_dm_d = grant_dm;
          if (grant_dm) begin
            we_d    = dm_we;
            sel_d   = dm_sel;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            state_d = BUSY_DM;
          end else begin
            we_d    = 1'b0;
            sel_d   = 4'b1111;
            addr_d  = if_addr;
            wdata_d = '0;
            state_d = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (ram_ready) begin
          done  = 1'b1;
          err_d = 1'b0;
          if (busy_dm) dm_rdata_d = ram_rdata;
          else         if_rdata_d = ram_rdata;
        end else if (cnt_q == TO_LAST) begin
          done  = 1'b1;
          err_d = 1'b1;
          if (busy_dm) dm_rdata_d = '0;
          else         if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          // Drop ce and we together so a write strobe never outlives ce.
          ce_d     = 1'b0;
          we_d     = 1'b0;
          if_ack_d = ~busy_dm;
          dm_ack_d = busy_dm;
          state_d  = busy_dm ? RESP_DM : RESP_IF;
        end
      end
      RESP_IF, RESP_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dm_q  <= 1'b0;
      cnt_q      <= '0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dm_q  <= last_dm_d;
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign ram_ce    = ce_q;
  assign ram_we    = we_q;
  assign ram_sel   = sel_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_dm  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: driver pushes expected responses, negedge monitor pops
// and compares on every ack; a small RAM model answers with set latency.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_sel = 4'hF;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        if_ack, dm_ack, err, ram_ce, ram_we, stall_if, stall_dm;
  logic        ram_ready = 1'b0;
  logic [3:0]  ram_sel;

  typedef struct { bit is_dm; logic [31:0] rdata; bit err; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0, acks_seen = 0, cyc = 0, last_ack_cyc = 0;
  int lat = 1, busy_cnt = 0;
  bit ready_force = 0, we_seen = 0;

  mem_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .err(err),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h3402_0020;
      32'h200: return 32'h1111_2222;
      32'h040: return 32'hCAFE_F00D;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // RAM model: ready rises lat cycles after ce rises (lat<0: never).
  always @(negedge clk) begin
    if (!ram_ce) busy_cnt = 0;
    else         busy_cnt = busy_cnt + 1;
    if (ram_we) we_seen = 1;
    ram_ready = ready_force || (ram_ce && lat >= 0 && busy_cnt == lat);
    ram_rdata = ram_ce ? (ram_we ? 32'h0 : mem_rd(ram_addr)) : 32'h5A5A_5A5A;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ack.
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_only_with_ce", ram_we & ~ram_ce, 0);
      chk("stall_if", stall_if, if_req & ~if_ack);
      chk("stall_dm", stall_dm, dm_req & ~dm_ack);
      if (if_ack || dm_ack) begin
        acks_seen++;
        last_ack_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b with nothing expected", if_ack, dm_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", {if_ack, dm_ack}, e.is_dm ? 2'b01 : 2'b10);
          chk("rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
          chk("err", err, e.err);
        end
      end
    end
  end

  task automatic push(input bit is_dm, input logic [31:0] d, input bit e);
    exp_t x;
    x.is_dm = is_dm; x.rdata = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_acks(input int target, input int bound, input string name);
    int n = 0;
    while (acks_seen < target && n < bound) begin @(posedge clk); #1; n++; end
    checks++;
    if (acks_seen < target) begin
      failures++;
      $display("FAIL %s: acks %0d expected %0d within %0d cycles", name, acks_seen, target, bound);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {ram_ce, ram_we, ram_sel, if_ack, dm_ack, err}, 0);
    chk({name, "_data"}, {ram_addr, ram_wdata, if_rdata, dm_rdata}, 0);
  endtask

  // One access: request held for the granting edge only, then dropped.
  task automatic access(input bit is_dm, input logic [31:0] a, input int exp_lat, input string name);
    int e0, base;
    base = acks_seen;
    if (is_dm) begin dm_addr = a; dm_req = 1; end
    else       begin if_addr = a; if_req = 1; end
    @(posedge clk); #1;
    e0 = cyc;
    if_req = 0; dm_req = 0;
    wait_acks(base + 1, 40, name);
    chk({name, "_latency"}, last_ack_cyc - e0, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_state");
    rst = 0;
    @(posedge clk); #1;

    // Single IF read, latency 1, no write strobe.
    lat = 1; we_seen = 0;
    push(0, 32'h3402_0020, 0);
    access(0, 32'h100, 1, "if_read");
    chk("if_read_no_we", we_seen, 0);

    // Tie after reset: DM, IF, DM, IF.
    rst = 1; @(posedge clk); #1 rst = 0; @(posedge clk); #1;
    push(1, 32'hCAFE_F00D, 0); push(0, 32'h1111_2222, 0);
    push(1, 32'hCAFE_F00D, 0); push(0, 32'h1111_2222, 0);
    dm_addr = 32'h40; if_addr = 32'h200; dm_req = 1; if_req = 1;
    base = acks_seen;
    wait_acks(base + 4, 100, "round_robin");
    dm_req = 0; if_req = 0;
    repeat (2) @(posedge clk); #1;

    // DM partial write.
    dm_we = 1; dm_sel = 4'b0011; dm_wdata = 32'hDEAD_BEEF; dm_addr = 32'h20;
    push(1, 32'h0, 0);
    base = acks_seen;
    dm_req = 1;
    @(posedge clk); #1;
    dm_req = 0;
    chk("write_cmd", {ram_ce, ram_we, ram_sel, ram_addr, ram_wdata},
        {1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF});
    wait_acks(base + 1, 40, "dm_write");
    dm_we = 0; dm_sel = 4'hF;
    @(posedge clk); #1;

    // Timeout after 16 BUSY cycles, then a clean access clears err.
    lat = -1;
    push(0, 32'h0, 1);
    access(0, 32'h100, 16, "timeout");
    lat = 1;
    push(1, 32'hCAFE_F00D, 0);
    access(1, 32'h40, 1, "after_timeout");

    // Reset mid BUSY_DM with a fetch waiting behind it.
    lat = -1;
    dm_addr = 32'h44; dm_req = 1;
    @(posedge clk); #1;
    dm_req = 0; if_addr = 32'h200; if_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1;
    #1 chk_zero("async_reset");
    lat = 1;
    push(0, 32'h1111_2222, 0);
    base = acks_seen;
    @(posedge clk); @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("grant_after_reset", {ram_ce, ram_we, ram_addr}, {1'b1, 1'b0, 32'h200});
    if_req = 0;
    wait_acks(base + 1, 40, "if_after_reset");
    @(posedge clk); #1;

    // Stray ready while idle: ignored, data held, next access normal.
    ready_force = 1;
    @(posedge clk); #1 ready_force = 0;
    @(posedge clk); #1;
    chk("idle_ready_ce", ram_ce, 0);
    chk("idle_ready_hold", if_rdata, 32'h1111_2222);
    push(0, 32'h3402_0020, 0);
    access(0, 32'h100, 1, "after_idle_ready");

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, giving the maximum BUSY cycles to wait for ram_ready (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port if_req, input, 1 bit: instruction-fetch read request.
REQ-005 SHALL have port if_addr, input, 32 bits: fetch byte address.
REQ-006 SHALL have port if_rdata, output, 32 bits: fetch read data, valid while if_ack=1.
REQ-007 SHALL have port if_ack, output, 1 bit: fetch completion pulse.
REQ-008 SHALL have port dm_req, input, 1 bit: data-memory request.
REQ-009 SHALL have port dm_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port dm_sel, input, 4 bits: byte enables.
REQ-011 SHALL have port dm_addr, input, 32 bits: data byte address.
REQ-012 SHALL have port dm_wdata, input, 32 bits: write data.
REQ-013 SHALL have port dm_rdata, output, 32 bits: data read result, valid while dm_ack=1.
REQ-014 SHALL have port dm_ack, output, 1 bit: data completion pulse.
REQ-015 SHALL have port err, output, 1 bit: asserted with an ack when that access timed out.
REQ-016 SHALL have ports ram_ce, ram_we, ram_sel[3:0], ram_addr[31:0], ram_wdata[31:0], all outputs (registered): the shared single-port RAM command.
REQ-017 SHALL have ports ram_rdata[31:0] and ram_ready (1 bit), both inputs: RAM read data and completion strobe.
REQ-018 SHALL have ports stall_if and stall_dm, outputs, 1 bit each: pipeline stall requests.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, RESP_IF and RESP_DM.
REQ-020 In IDLE with exactly one request pending, SHALL grant that requester, latch its command into the ram_* registers and move to BUSY_x.
REQ-021 In IDLE with both requests pending, SHALL grant the requester not granted last (round-robin); the last-grant register SHALL reset to IF so DM wins the first tie.
REQ-022 For IF grants, SHALL drive ram_we=0 and ram_sel=4'b1111; for DM grants, SHALL drive ram_we=dm_we and ram_sel=dm_sel.
REQ-023 In BUSY_x, SHALL hold ram_ce=1 and all ram_* fields stable, and SHALL increment an 8-bit wait counter that is cleared on entry.
REQ-024 When ram_ready=1 is sampled in BUSY_x, SHALL capture ram_rdata into the x_rdata register, set err=0 and move to RESP_x.
REQ-025 When the wait counter reaches TIMEOUT_CYC without ram_ready, SHALL set x_rdata=0 and err=1 and move to RESP_x.
REQ-026 In RESP_x, SHALL assert x_ack for exactly one cycle with ram_ce=0, then return to IDLE.
REQ-027 Minimum latency SHALL be: request sampled at edge 0, ram_ready sampled at edge 1, ack high between edges 1 and 2.
REQ-028 x_rdata and err SHALL hold their values until the next capture.
REQ-029 ram_we SHALL never be 1 unless ram_ce=1.
REQ-030 A requester deasserting req while in BUSY_x SHALL NOT abort the access: the access completes and the ack is still pulsed.
REQ-031 A req held high through its ack cycle SHALL be treated as a new request at the following IDLE sample.
REQ-032 stall_if SHALL equal if_req & ~if_ack, and stall_dm SHALL equal dm_req & ~dm_ack (combinational).
REQ-033 ram_ready sampled outside BUSY_x SHALL be ignored.

Reset
REQ-034 Asserting rst SHALL immediately force IDLE, clear ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, if_ack, dm_ack, err, if_rdata, dm_rdata and the wait counter to 0, and set last-grant to IF.
REQ-035 An access in flight when rst asserts SHALL be discarded with no ack; the first edge after rst deasserts SHALL evaluate requests from IDLE.

Verification
REQ-036 Single IF read: if_addr=0x100, RAM returns 0x3402_0020 with ready after 1 cycle -> one-cycle if_ack, if_rdata=0x34020020, err=0, ram_we=0 throughout.
REQ-037 Simultaneous if_req and dm_req after reset -> DM served first, then IF; with both held high, grants alternate DM, IF, DM, IF.
REQ-038 DM write: dm_addr=0x20, dm_sel=4'b0011, dm_wdata=0xDEADBEEF -> ram_we=1, ram_sel=4'b0011 only while ram_ce=1; dm_ack one cycle after ram_ready.
REQ-039 ram_ready never asserted, TIMEOUT_CYC=16 -> ack after 16 BUSY cycles with err=1 and rdata=0; the next access completes normally with err=0.
REQ-040 rst asserted mid-BUSY_DM -> all outputs 0 asynchronously, no dm_ack; a pending if_req is granted on the first edge after release.
REQ-041 ram_ready pulsed while the FSM is IDLE -> no ack and no state change.
